// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - single-clock parametrised FIFO with thresholds and sticky error flags
//
// Purpose: same-clock-domain buffer between producer and consumer logic.
//   Occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow.
// Build option: FIFO_SYNC_FWFT_EN selects first-word-fall-through output;
//   undefined (default) gives registered read with 1-cycle pop-to-data latency.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   synch_rst    synchronous clear, overrides push/pop
//   push, pop    write / read requests
//   data_input   write data, sampled on an accepted push
//   data_out     read data (registered or FWFT)
//   full_out, empty_out, almost_full, almost_empty  decodes of the count register
//   count        occupancy 0..DEPTH
//   overflow     sticky: push attempted while full
//   underflow    sticky: pop attempted while empty
module fifo_sync_param #(
  parameter int WORDLENGHT = 8,
  parameter int DEPTH      = 8,
  parameter int AF_TH      = DEPTH - 2,
  parameter int AE_TH      = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     synch_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WORDLENGHT-1:0]    data_input,
  output logic [WORDLENGHT-1:0]    data_out,
  output logic                     full_out,
  output logic                     empty_out,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WORDLENGHT-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  push_acc, pop_acc;

  // Status flags decode only the count register, never push/pop.
  assign full_out     = (count_q == CW'(DEPTH));
  assign empty_out    = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_TH));
  assign almost_empty = (count_q <= CW'(AE_TH));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Full/empty block only their own side, so push+pop at full still drains
  // one word and push+pop at empty still loads one word.
  assign push_acc = push && !full_out  && !synch_rst;
  assign pop_acc  = pop  && !empty_out && !synch_rst;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (synch_rst) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push && full_out)  overflow_d  = 1'b1;
      if (pop  && empty_out) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is intentionally not cleared by either reset.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= data_input;
  end

`ifdef FIFO_SYNC_FWFT_EN
  // Head word is shown directly; pop just advances past it.
  assign data_out = empty_out ? '0 : mem_q[rd_ptr_q];
`else
  logic [WORDLENGHT-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (synch_rst)    dout_d = '0;
    else if (pop_acc) dout_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - scoreboard testbench for fifo_sync_param
module tb_fifo_sync_param;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 1;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          synch_rst;
  logic          push;
  logic          pop;
  logic [W-1:0]  data_input;
  logic [W-1:0]  data_out;
  logic          full_out, empty_out, almost_full, almost_empty;
  logic [CW-1:0] count;
  logic          overflow, underflow;

  fifo_sync_param #(.WORDLENGHT(W), .DEPTH(D), .AF_TH(AF), .AE_TH(AE)) dut (
    .clk          (clk),
    .reset        (reset),
    .synch_rst    (synch_rst),
    .push         (push),
    .pop          (pop),
    .data_input   (data_input),
    .data_out     (data_out),
    .full_out     (full_out),
    .empty_out    (empty_out),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] sb[$];
  int           m_cnt = 0;
  bit           m_ovf = 1'b0;
  bit           m_udf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_status();
    check("count",        32'(count),        32'(m_cnt));
    check("full_out",     32'(full_out),     32'(m_cnt == D));
    check("empty_out",    32'(empty_out),    32'(m_cnt == 0));
    check("almost_full",  32'(almost_full),  32'(m_cnt >= AF));
    check("almost_empty", 32'(almost_empty), 32'(m_cnt <= AE));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_udf));
`ifdef FIFO_SYNC_FWFT_EN
    check("fwft_head", 32'(data_out), (m_cnt != 0) ? 32'(sb[0]) : 32'd0);
`endif
  endtask

  task automatic model_clear();
    sb.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic step(input bit p, input bit q, input logic [W-1:0] d);
    bit           ap, aq;
    logic [W-1:0] exp;
    @(negedge clk);
    push = p; pop = q; data_input = d;
    ap  = p && (m_cnt != D);
    aq  = q && (m_cnt != 0);
    exp = '0;
    if (aq) exp = sb.pop_front();
`ifdef FIFO_SYNC_FWFT_EN
    #1;
    if (aq) check("fwft_data", 32'(data_out), 32'(exp));
`endif
    if (ap) sb.push_back(d);
    if (p && !ap) m_ovf = 1'b1;
    if (q && !aq) m_udf = 1'b1;
    m_cnt = m_cnt + int'(ap) - int'(aq);
    @(posedge clk);
    #1;
`ifndef FIFO_SYNC_FWFT_EN
    if (aq) check("rd_data", 32'(data_out), 32'(exp));
`endif
    push = 1'b0; pop = 1'b0;
    check_status();
  endtask

  task automatic sync_clear(input bit p);
    @(negedge clk);
    synch_rst = 1'b1; push = p; pop = 1'b1; data_input = 8'hEE;
    @(posedge clk);
    #1;
    synch_rst = 1'b0; push = 1'b0; pop = 1'b0;
    model_clear();
    check_status();
    check("srst_dout", 32'(data_out), 32'd0);
  endtask

  task automatic async_clear();
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    model_clear();
    check_status();
    check("arst_dout", 32'(data_out), 32'd0);
    #1 reset = 1'b0;
  endtask

  task automatic fill_to(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, base + W'(i));
  endtask

  task automatic drain();
    while (m_cnt != 0) step(1'b0, 1'b1, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; synch_rst = 1'b0; push = 1'b0; pop = 1'b0; data_input = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_status();
    check("reset_dout", 32'(data_out), 32'd0);

    // Fill 0x01..0x08, overflow attempt, drain, underflow attempt.
    fill_to(8, 8'h01);
    step(1'b1, 1'b0, 8'hAA);
    drain();
    step(1'b0, 1'b1, '0);
    repeat (3) step(1'b0, 1'b0, '0);
    sync_clear(1'b0);

    // Simultaneous push/pop at mid occupancy.
    fill_to(3, 8'h10);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 8'h20 + W'(i));
    drain();

    // Simultaneous at full, then at empty.
    fill_to(8, 8'h40);
    step(1'b1, 1'b1, 8'h55);
    drain();
    step(1'b1, 1'b1, 8'h66);
    drain();
    sync_clear(1'b0);

    // Wrap-around: three rounds of 6 words.
    for (int r = 0; r < 3; r++) begin
      fill_to(6, 8'h80 + W'(r * 6));
      drain();
    end

    // Synchronous clear with push at count=5, then async clear.
    fill_to(5, 8'hC0);
    sync_clear(1'b1);
    step(1'b0, 1'b1, '0);
    fill_to(5, 8'hD0);
    async_clear();
    fill_to(2, 8'hE0);
    drain();

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
